// File: rtl/dtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dtc_pkg
//  Purpose  : Shared types and constants for the decision-tree classifier
//             family and its downstream voting stage.
//  Contents : DTC_OUT_W   - label vector width of the classifiers
//             DTC_IDX_W   - width of a label index (covers DTC_OUT_W labels)
//             dtc_label_t - one classifier label vector
//             dtc_vote_state_t - voting stage states (ACCUM, SCAN, HOLD)
//  Revision : 1.0 - initial release
// ============================================================================
package dtc_pkg;

    localparam int DTC_OUT_W = 18;
    localparam int DTC_IDX_W = 5;

    typedef logic [DTC_OUT_W-1:0] dtc_label_t;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } dtc_vote_state_t;

endpackage : dtc_pkg
`default_nettype wire

// File: rtl/dtc_argmax_scan.sv
`default_nettype none
// ============================================================================
//  Module   : dtc_argmax_scan
//  Purpose  : Serial argmax over a vote-count array, one index per cycle.
//             A label replaces the running best only when its count is
//             strictly greater, so ties resolve to the lowest index and an
//             all-zero array yields index 0 / count 0.
//  Ports    : clk, rst_n  - clock, asynchronous active-low reset
//             start       - pulse: begin a scan on the next cycle
//             cnt_arr     - per-label vote counts (held stable while scanning)
//             done        - high during the last scan cycle
//             idx, cnt    - best index/count including the current index;
//                           final result when done is high
//  Revision : 1.0 - initial release
// ============================================================================
module dtc_argmax_scan
    import dtc_pkg::*;
#(
    parameter int OUT_W = DTC_OUT_W,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cnt_arr [OUT_W],
    output logic                 done,
    output logic [DTC_IDX_W-1:0] idx,
    output logic [CNT_W-1:0]     cnt
);

    localparam logic [DTC_IDX_W-1:0] c_last = DTC_IDX_W'(OUT_W - 1);

    logic                 r_busy;
    logic [DTC_IDX_W-1:0] r_j;
    logic [DTC_IDX_W-1:0] r_best_idx;
    logic [CNT_W-1:0]     r_best_cnt;

    logic [CNT_W-1:0]     w_cur;
    logic                 w_take;

    // The result including index r_j is exposed combinationally so the
    // caller can capture it on the same edge that ends the scan.
    always_comb begin
        w_cur  = cnt_arr[r_j];
        w_take = r_busy && (w_cur > r_best_cnt);
        idx    = w_take ? r_j   : r_best_idx;
        cnt    = w_take ? w_cur : r_best_cnt;
        done   = r_busy && (r_j == c_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_j        <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
        end else if (start) begin
            r_busy     <= 1'b1;
            r_j        <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
        end else if (r_busy) begin
            r_best_idx <= idx;
            r_best_cnt <= cnt;
            if (done) begin
                r_busy <= 1'b0;
            end else begin
                r_j <= r_j + 1'b1;
            end
        end
    end

endmodule : dtc_argmax_scan
`default_nettype wire

// File: rtl/dtc_vote_accum.sv
`default_nettype none
// ============================================================================
//  Module   : dtc_vote_accum
//  Purpose  : Temporal / ensemble voting stage for classifier label vectors.
//             Accumulates per-bit vote counts over a window of WIN samples
//             (or fewer on flush), then reports the per-bit majority vector
//             and the most-voted label with its count.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             s_valid/s_ready/s_vec - label vector input stream
//             flush                 - close the current window early (ACCUM)
//             m_valid/m_ready       - result handshake
//             m_vec                 - majority vector, bit i = (2*cnt[i] > n)
//             m_top_idx, m_top_cnt  - most-voted label (lowest index on ties)
//             m_n                   - samples in the closed window
//  Revision : 1.0 - initial release
// ============================================================================
module dtc_vote_accum
    import dtc_pkg::*;
#(
    parameter int OUT_W = DTC_OUT_W,
    parameter int WIN   = 8,
    parameter int CNT_W = $clog2(WIN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [OUT_W-1:0]     s_vec,
    input  logic                 flush,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_W-1:0]     m_vec,
    output logic [DTC_IDX_W-1:0] m_top_idx,
    output logic [CNT_W-1:0]     m_top_cnt,
    output logic [CNT_W-1:0]     m_n
);

    localparam logic [CNT_W-1:0] c_win = CNT_W'(WIN);

    dtc_vote_state_t      r_state;
    logic [CNT_W-1:0]     r_cnt [OUT_W];
    logic [CNT_W-1:0]     r_n;

    logic                 r_m_valid;
    logic [OUT_W-1:0]     r_m_vec;
    logic [DTC_IDX_W-1:0] r_m_top_idx;
    logic [CNT_W-1:0]     r_m_top_cnt;
    logic [CNT_W-1:0]     r_m_n;

    logic                 w_accept;
    logic                 w_close;
    logic                 w_release;
    logic [CNT_W-1:0]     w_cnt_nxt [OUT_W];
    logic [CNT_W-1:0]     w_n_nxt;
    logic [OUT_W-1:0]     w_maj;

    logic                 w_scan_done;
    logic [DTC_IDX_W-1:0] w_scan_idx;
    logic [CNT_W-1:0]     w_scan_cnt;

    assign s_ready   = (r_state == ACCUM);
    assign w_accept  = s_ready && s_valid;
    assign w_release = (r_state == HOLD) && m_ready;

    // Counts after any accept in this cycle. The majority vector is taken
    // from these so a sample accepted together with flush is included.
    always_comb begin
        w_n_nxt = r_n + CNT_W'(w_accept);
        for (int i = 0; i < OUT_W; i++) begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(w_accept & s_vec[i]);
            w_maj[i]     = {w_cnt_nxt[i], 1'b0} > {1'b0, w_n_nxt};
        end
    end

    // A flush on an empty window with no accept is a no-op.
    assign w_close = s_ready &&
                     ((w_accept && (w_n_nxt == c_win)) ||
                      (flush && (w_n_nxt != '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n <= '0;
            for (int i = 0; i < OUT_W; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_release) begin
            r_n <= '0;
            for (int i = 0; i < OUT_W; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_accept) begin
            r_n   <= w_n_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // The scanner reads r_cnt, which stays frozen from window close until
    // the result is released.
    dtc_argmax_scan #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_close),
        .cnt_arr (r_cnt),
        .done    (w_scan_done),
        .idx     (w_scan_idx),
        .cnt     (w_scan_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_m_valid   <= 1'b0;
            r_m_vec     <= '0;
            r_m_top_idx <= '0;
            r_m_top_cnt <= '0;
            r_m_n       <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_close) begin
                        r_state <= SCAN;
                        r_m_vec <= w_maj;
                        r_m_n   <= w_n_nxt;
                    end
                end
                SCAN: begin
                    if (w_scan_done) begin
                        r_state     <= HOLD;
                        r_m_valid   <= 1'b1;
                        r_m_top_idx <= w_scan_idx;
                        r_m_top_cnt <= w_scan_cnt;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        r_state   <= ACCUM;
                        r_m_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ACCUM;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid   = r_m_valid;
    assign m_vec     = r_m_vec;
    assign m_top_idx = r_m_top_idx;
    assign m_top_cnt = r_m_top_cnt;
    assign m_n       = r_m_n;

endmodule : dtc_vote_accum
`default_nettype wire

// File: tb/tb_dtc_vote_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dtc_vote_accum
//  Purpose  : Self-checking bench for dtc_vote_accum: directed scenarios with
//             literal expectations plus randomized traffic, all compared
//             every cycle against a window-level behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dtc_vote_accum;

    localparam int OUT_W = 18;
    localparam int WIN   = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [OUT_W-1:0] s_vec = '0;
    logic             flush = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [OUT_W-1:0] m_vec;
    logic [4:0]       m_top_idx;
    logic [CNT_W-1:0] m_top_cnt;
    logic [CNT_W-1:0] m_n;

    int checks = 0;
    int errors = 0;

    dtc_vote_accum #(.OUT_W(OUT_W), .WIN(WIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_vec     (s_vec),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_vec     (m_vec),
        .m_top_idx (m_top_idx),
        .m_top_cnt (m_top_cnt),
        .m_n       (m_n)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 = collecting, 1 = computing, 2 = result
    // ------------------------------------------------------------------
    int          mcnt [OUT_W];
    int          mn;
    int          mphase;
    int          scan_left;
    logic [17:0] e_vec;
    int          e_idx;
    int          e_tcnt;
    int          e_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            mn = 0; mphase = 0; scan_left = 0;
            e_vec = '0; e_idx = 0; e_tcnt = 0; e_n = 0;
        end else begin
            case (mphase)
                0: begin
                    if (s_valid) begin
                        for (int i = 0; i < OUT_W; i++) mcnt[i] += int'(s_vec[i]);
                        mn++;
                    end
                    if ((s_valid && mn == WIN) || (flush && mn >= 1)) begin
                        int mx;
                        e_n = mn;
                        mx  = 0;
                        for (int i = 0; i < OUT_W; i++) begin
                            e_vec[i] = (2 * mcnt[i] > mn);
                            if (mcnt[i] > mx) mx = mcnt[i];
                        end
                        e_idx  = 0;
                        e_tcnt = mx;
                        if (mx > 0) begin
                            for (int i = OUT_W - 1; i >= 0; i--)
                                if (mcnt[i] == mx) e_idx = i;
                        end
                        mphase    = 1;
                        scan_left = OUT_W;
                    end
                end
                1: begin
                    scan_left--;
                    if (scan_left == 0) mphase = 2;
                end
                default: begin
                    if (m_ready) begin
                        foreach (mcnt[i]) mcnt[i] = 0;
                        mn     = 0;
                        mphase = 0;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_s_ready", 32'(s_ready), 32'(mphase == 0));
            chk("cyc_m_valid", 32'(m_valid), 32'(mphase == 2));
            if (mphase == 2) begin
                chk("cyc_m_vec",     32'(m_vec),     32'(e_vec));
                chk("cyc_m_top_idx", 32'(m_top_idx), 32'(e_idx));
                chk("cyc_m_top_cnt", 32'(m_top_cnt), 32'(e_tcnt));
                chk("cyc_m_n",       32'(m_n),       32'(e_n));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called aligned to a falling edge)
    // ------------------------------------------------------------------
    task automatic drive(input logic v, input logic [17:0] vec, input logic fl, input logic mr);
        s_valid = v; s_vec = vec; flush = fl; m_ready = mr;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int maxc, output int cycles);
        cycles = 0;
        while (!m_valid && cycles < maxc) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            cycles++;
        end
        if (!m_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_m_valid: got timeout after %0d cycles expected m_valid", cycles);
        end
    endtask

    task automatic expect_result(input string tag, input logic [17:0] vec, input int idx,
                                 input int tcnt, input int n);
        chk({tag, "_m_vec"},     32'(m_vec),     32'(vec));
        chk({tag, "_m_top_idx"}, 32'(m_top_idx), 32'(idx));
        chk({tag, "_m_top_cnt"}, 32'(m_top_cnt), 32'(tcnt));
        chk({tag, "_m_n"},       32'(m_n),       32'(n));
    endtask

    int          cyc;
    logic [17:0] held_vec;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        chk("rst_s_ready",   32'(s_ready),   32'd1);
        chk("rst_m_valid",   32'(m_valid),   32'd0);
        expect_result("rst", 18'h0, 0, 0, 0);

        // Full window of bit 17; latency counts the accepting edge
        for (int i = 0; i < 8; i++) drive(1'b1, 18'h20000, 1'b0, 1'b1);
        wait_valid(40, cyc);
        chk("latency", 32'(cyc + 1), 32'd19);
        expect_result("full", 18'h20000, 17, 8, 8);
        drive(1'b0, '0, 1'b0, 1'b1);

        // Short window closed by a flush; bit0 at exactly half is not majority
        drive(1'b1, 18'h00001, 1'b0, 1'b0);
        drive(1'b1, 18'h00003, 1'b0, 1'b0);
        drive(1'b1, 18'h00002, 1'b0, 1'b0);
        drive(1'b1, 18'h00002, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        wait_valid(40, cyc);
        expect_result("flush4", 18'h00002, 1, 3, 4);
        drive(1'b0, '0, 1'b0, 1'b1);

        // Empty flush is ignored
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("empty_flush_s_ready", 32'(s_ready), 32'd1);
        chk("empty_flush_m_valid", 32'(m_valid), 32'd0);

        // Tie between bit 3 and bit 5 resolves to the lower index
        for (int i = 0; i < 8; i++) drive(1'b1, (i < 4) ? 18'h00028 : 18'h0, 1'b0, 1'b0);
        wait_valid(40, cyc);
        expect_result("tie", 18'h0, 3, 4, 8);

        // Backpressure: result held, inputs ignored while not ready
        held_vec = m_vec;
        for (int i = 0; i < 10; i++) drive(1'b1, 18'($urandom), 1'b1, 1'b0);
        chk("bp_s_ready", 32'(s_ready), 32'd0);
        chk("bp_m_vec",   32'(m_vec),   32'(held_vec));
        expect_result("bp", 18'h0, 3, 4, 8);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("bp_released", 32'(m_valid), 32'd0);
        // One sample after release proves the counts were cleared
        drive(1'b1, 18'h00001, 1'b1, 1'b0);
        wait_valid(40, cyc);
        expect_result("cleared", 18'h00001, 0, 1, 1);
        drive(1'b0, '0, 1'b0, 1'b1);

        // Flush together with the 3rd accept includes that sample
        drive(1'b1, 18'h00101, 1'b0, 1'b0);
        drive(1'b1, 18'h00001, 1'b0, 1'b0);
        drive(1'b1, 18'h00100, 1'b1, 1'b0);
        wait_valid(40, cyc);
        expect_result("flush_acc", 18'h00101, 0, 2, 3);
        drive(1'b0, '0, 1'b0, 1'b1);

        // Reset in the middle of a scan
        drive(1'b1, 18'h00004, 1'b0, 1'b0);
        drive(1'b1, 18'h00004, 1'b1, 1'b0);
        repeat (5) drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd1);
        expect_result("midrst", 18'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 18'h00010, 1'b1, 1'b0);
        wait_valid(40, cyc);
        expect_result("postrst", 18'h00010, 4, 1, 1);
        drive(1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 1)), 18'($urandom) & 18'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dtc_vote_accum
`default_nettype wire
